// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// FUNCT3 width/sign codes, FSM state encoding and request legality helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Stores only know B/H/W; loads additionally have the unsigned forms.
    function automatic logic f3_legal(input logic is_load,
                                      input logic [2:0] f3);
        logic ok;
        if (is_load)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return ok;
    endfunction

    // Width is carried by FUNCT3[1:0] for both signed and unsigned forms.
    function automatic logic f3_aligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: selects the addressed byte/half of the raw memory word
// and sign- or zero-extends it. Ports: rdata_i, offset_i, funct3_i -> result_o.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        result_o = rdata_i;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ack handshake with a multi-cycle
// data memory, store lane steering, load alignment/extension and pipeline
// stall. Ports: pipeline side (MEM_READ/WRITE, FUNCT3, ADDRESS, WRITE_DATA,
// READ_DATA, BUSYWAIT, ACCESS_ERROR) and memory side (DMEM_*).
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ACCESS_ERROR,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    output logic [29:0] DMEM_ADDRESS,
    output logic [31:0] DMEM_WRITEDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic [31:0] DMEM_READDATA,
    input  logic        DMEM_ACK
);

    state_t      state_q, state_d;
    logic        rd_q, wr_q, err_q, err_d;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q, wdata_st;
    logic [3:0]  en_q, en_st;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_res;
    logic        req, ok, idle, accept;

    // A read wins over a write when both are asserted.
    assign req    = MEM_READ | MEM_WRITE;
    assign ok     = f3_legal(MEM_READ, FUNCT3) &
                    f3_aligned(FUNCT3, ADDRESS[1:0]);
    assign idle   = (state_q == IDLE);
    assign accept = idle & req & ok;
    assign err_d  = idle & req & ~ok;

    always_comb begin
        wdata_st = WRITE_DATA;
        en_st    = 4'b1111;
        case (FUNCT3[1:0])
            2'b00: begin
                wdata_st = {4{WRITE_DATA[7:0]}};
                en_st    = 4'b0001 << ADDRESS[1:0];
            end
            2'b01: begin
                wdata_st = {2{WRITE_DATA[15:0]}};
                en_st    = ADDRESS[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        BUSYWAIT = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    BUSYWAIT = 1'b1;
                    state_d  = MEM_READ ? READ_WAIT : WRITE_WAIT;
                end
            end
            READ_WAIT: begin
                BUSYWAIT = 1'b1;
                if (DMEM_ACK) state_d = DONE;
            end
            WRITE_WAIT: begin
                BUSYWAIT = 1'b1;
                if (DMEM_ACK) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata_i  (DMEM_READDATA),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (load_res)
    );

    // Errors clear the load result so a faulting load never forwards stale data.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == READ_WAIT && DMEM_ACK) rdata_d = load_res;
        else if (err_d)                       rdata_d = '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            en_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= (state_d == READ_WAIT);
            wr_q    <= (state_d == WRITE_WAIT);
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= ADDRESS[31:2];
                off_q   <= ADDRESS[1:0];
                f3_q    <= FUNCT3;
                wdata_q <= wdata_st;
                en_q    <= en_st;
            end
        end
    end

    assign READ_DATA      = rdata_q;
    assign ACCESS_ERROR   = err_q;
    assign DMEM_READ      = rd_q;
    assign DMEM_WRITE     = wr_q;
    assign DMEM_ADDRESS   = addr_q;
    assign DMEM_WRITEDATA = wdata_q;
    assign DMEM_BYTE_EN   = en_q;

endmodule
